pipe_hazard_ctrl: RTL and testbench

//  Hazard/control responder for the 5-stage RISC-V pipeline: consumes datapath hazard taps (source/dest regs, regwrite, resultsrce, pcsrce)
//  and drives stallf/stalld/flushd/flushe and forwarding selects fwae/fwbe back into the datapath.

---
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/control responder for a 5-stage RISC-V pipeline: forwarding selects, load-use stall,
// redirect flush, startup flush sequence, debug halt/drain/single-step and saturating event counters.
module pipe_hazard_ctrl #(
  parameter int INIT_FLUSH = 3,
  parameter int DRAIN_CYC  = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1d,
  input  logic [4:0]       rs2d,
  input  logic [4:0]       rs1e,
  input  logic [4:0]       rs2e,
  input  logic [4:0]       rde,
  input  logic [4:0]       rdm,
  input  logic [4:0]       rdw,
  input  logic             regwritem,
  input  logic             regwritew,
  input  logic [1:0]       resultsrce,
  input  logic [1:0]       pcsrce,
  input  logic             halt_req,
  input  logic             step,
  output logic             stallf,
  output logic             stalld,
  output logic             flushd,
  output logic             flushe,
  output logic [1:0]       fwae,
  output logic [1:0]       fwbe,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MAX_CYC = (INIT_FLUSH > DRAIN_CYC) ? INIT_FLUSH : DRAIN_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] INIT_LOAD  = CW'(INIT_FLUSH - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_STEP
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lduse, redir, count_en;

  // M-stage result is newer than W, so it takes priority; x0 is never a real dependency.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm, input logic [4:0] rm,
                                         input logic ww, input logic [4:0] rw);
    if (wm && rm != 5'd0 && rm == rs)      return 2'b10;
    else if (ww && rw != 5'd0 && rw == rs) return 2'b01;
    else                                   return 2'b00;
  endfunction

  assign fwae  = fwd_sel(rs1e, regwritem, rdm, regwritew, rdw);
  assign fwbe  = fwd_sel(rs2e, regwritem, rdm, regwritew, rdw);
  assign lduse = (resultsrce == 2'b01) && (rde != 5'd0) && ((rde == rs1d) || (rde == rs2d));
  assign redir = (pcsrce != 2'b00);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    stallf = 1'b0;
    stalld = 1'b0;
    flushd = 1'b0;
    flushe = 1'b0;
    case (state_q)
      S_INIT: begin
        stallf = 1'b1;
        flushd = 1'b1;
        flushe = 1'b1;
      end
      S_RUN: begin
        stallf = lduse & ~redir;
        stalld = lduse & ~redir;
        flushd = redir;
        flushe = lduse | redir;
      end
      S_DRAIN: begin
        // A branch resolving during drain must still land: PC takes the target, D is cleared.
        stallf = ~redir;
        stalld = ~redir;
        flushd = redir;
        flushe = 1'b1;
      end
      S_HALTED: begin
        stallf = 1'b1;
        stalld = 1'b1;
        flushe = 1'b1;
      end
      S_STEP: begin
        flushd = redir;
        flushe = redir;
      end
      default: begin
        stallf = 1'b1;
        flushd = 1'b1;
        flushe = 1'b1;
      end
    endcase
  end

  assign halt_ack = (state_q == S_HALTED);

  assign count_en    = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_STEP);
  assign stall_cnt_d = (count_en && lduse && !redir && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1)
                                                                           : stall_cnt_q;
  assign flush_cnt_d = (count_en && redir && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1)
                                                                : flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      cnt_q   <= INIT_LOAD;
    end else begin
      case (state_q)
        S_INIT: begin
          if (cnt_q == '0) state_q <= S_RUN;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        S_RUN: begin
          if (halt_req) begin
            state_q <= S_DRAIN;
            cnt_q   <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) state_q <= S_HALTED;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        S_HALTED: begin
          if (!halt_req) state_q <= S_RUN;
          else if (step) state_q <= S_STEP;
        end
        S_STEP: begin
          state_q <= S_DRAIN;
          cnt_q   <= DRAIN_LOAD;
        end
        default: begin
          state_q <= S_INIT;
          cnt_q   <= INIT_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the control rules; a second instance with 2-bit counters exercises saturation.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int INIT_FLUSH = 3;
  localparam int DRAIN_CYC  = 3;
  localparam int CNT_W      = 16;
  localparam int SAT_W      = 2;
  localparam int M_INIT = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3, M_STEP = 4;
  localparam logic [8:0] CTL_INIT = 9'b1011_0000_0;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic regwritem, regwritew, halt_req, step;
  logic [1:0] resultsrce, pcsrce;

  logic stallf, stalld, flushd, flushe, halt_ack;
  logic [1:0] fwae, fwbe;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic s_stallf, s_stalld, s_flushd, s_flushe, s_halt_ack;
  logic [1:0] s_fwae, s_fwbe;
  logic [SAT_W-1:0] s_stall_cnt, s_flush_cnt;

  logic [8:0]  obs_ctl;
  logic [35:0] obs_cnt;
  assign obs_ctl = {stallf, stalld, flushd, flushe, fwae, fwbe, halt_ack};
  assign obs_cnt = {stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt};

  int checks = 0;
  int errors = 0;

  // Model state: current mode, cycles left in a timed phase, and true (unclipped) event totals.
  int     m_mode, m_left;
  longint m_stall, m_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.INIT_FLUSH(INIT_FLUSH), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e),
    .rde(rde), .rdm(rdm), .rdw(rdw), .regwritem(regwritem), .regwritew(regwritew),
    .resultsrce(resultsrce), .pcsrce(pcsrce), .halt_req(halt_req), .step(step),
    .stallf(stallf), .stalld(stalld), .flushd(flushd), .flushe(flushe),
    .fwae(fwae), .fwbe(fwbe), .halt_ack(halt_ack), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.INIT_FLUSH(INIT_FLUSH), .DRAIN_CYC(DRAIN_CYC), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e),
    .rde(rde), .rdm(rdm), .rdw(rdw), .regwritem(regwritem), .regwritew(regwritew),
    .resultsrce(resultsrce), .pcsrce(pcsrce), .halt_req(halt_req), .step(step),
    .stallf(s_stallf), .stalld(s_stalld), .flushd(s_flushd), .flushe(s_flushe),
    .fwae(s_fwae), .fwbe(s_fwbe), .halt_ack(s_halt_ack), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (regwritem && rdm != 0 && rdm == rs)      return 2'b10;
    else if (regwritew && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_lduse();
    return resultsrce == 2'b01 && rde != 0 && (rde == rs1d || rde == rs2d);
  endfunction

  // Expected {stallf,stalld,flushd,flushe,fwae,fwbe,halt_ack} for the current mode and inputs.
  function automatic logic [8:0] model_ctl();
    logic       rd, ld;
    logic [3:0] h;
    rd = (pcsrce != 2'b00);
    ld = model_lduse();
    case (m_mode)
      M_INIT:   h = 4'b1011;
      M_RUN:    h = rd ? 4'b0011 : (ld ? 4'b1101 : 4'b0000);
      M_DRAIN:  h = rd ? 4'b0011 : 4'b1101;
      M_HALTED: h = 4'b1101;
      default:  h = {2'b00, rd, rd};
    endcase
    return {h, ref_fwd(rs1e), ref_fwd(rs2e), (m_mode == M_HALTED)};
  endfunction

  function automatic logic [CNT_W-1:0] clip(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return CNT_W'((v > lim) ? lim : v);
  endfunction

  function automatic logic [35:0] model_cnt();
    logic [CNT_W-1:0] a, b, c, d;
    a = clip(m_stall, CNT_W);
    b = clip(m_flush, CNT_W);
    c = clip(m_stall, SAT_W);
    d = clip(m_flush, SAT_W);
    return {a, b, c[1:0], d[1:0]};
  endfunction

  task automatic model_reset();
    m_mode  = M_INIT;
    m_left  = INIT_FLUSH;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_update();
    logic rd;
    if (!rst) return;
    rd = (pcsrce != 2'b00);
    if (m_mode == M_RUN || m_mode == M_DRAIN || m_mode == M_STEP) begin
      if (rd) m_flush++;
      else if (model_lduse()) m_stall++;
    end
    case (m_mode)
      M_INIT: begin
        m_left--;
        if (m_left == 0) m_mode = M_RUN;
      end
      M_RUN: if (halt_req) begin m_mode = M_DRAIN; m_left = DRAIN_CYC; end
      M_DRAIN: begin
        m_left--;
        if (m_left == 0) m_mode = M_HALTED;
      end
      M_HALTED: begin
        if (!halt_req) m_mode = M_RUN;
        else if (step) m_mode = M_STEP;
      end
      default: begin m_mode = M_DRAIN; m_left = DRAIN_CYC; end
    endcase
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
    {regwritem, regwritew, halt_req, step} = '0;
    resultsrce = 2'b00;
    pcsrce     = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs_ctl !== CTL_INIT) begin errors++; $display("FAIL reset_ctl: got %b expected %b", obs_ctl, CTL_INIT); end
      checks++;
      if (obs_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", obs_cnt); end
      if (i == 0) advance();
    end
    rst = 1'b1;
    for (int i = 0; i < INIT_FLUSH; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs_ctl !== CTL_INIT) begin errors++; $display("FAIL startup_init[%0d]: got %b expected %b", i, obs_ctl, CTL_INIT); end
      advance();
    end
    @(negedge clk);
    checks++;
    if (obs_ctl !== 9'b0) begin errors++; $display("FAIL startup_run: got %b expected 000000000", obs_ctl); end
    advance();
  endtask

  task automatic test_forwarding();
    regwritem = 1; rdm = 5; regwritew = 1; rdw = 5; rs1e = 5; rs2e = 0;
    @(negedge clk);
    checks++;
    if ({fwae, fwbe} !== 4'b1000) begin errors++; $display("FAIL fwd_m_prio: got %b%b expected 1000", fwae, fwbe); end
    rdm = 0;
    #1;
    checks++;
    if (fwae !== 2'b01) begin errors++; $display("FAIL fwd_w_rdm0: got %b expected 01", fwae); end
    regwritem = 0; rdm = 9; rs2e = 9; regwritew = 1; rdw = 0; rs1e = 0;
    #1;
    checks++;
    if ({fwae, fwbe} !== 4'b0000) begin errors++; $display("FAIL fwd_x0_and_nowrite: got %b%b expected 0000", fwae, fwbe); end
    advance();
    for (int i = 0; i < 40; i++) begin
      rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
      rdm  = 5'($urandom_range(0, 3)); rdw  = 5'($urandom_range(0, 3));
      regwritem = 1'($urandom_range(0, 1)); regwritew = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({fwae, fwbe} !== {ref_fwd(rs1e), ref_fwd(rs2e)})
        begin errors++; $display("FAIL fwd_rand[%0d]: got %b%b expected %b%b", i, fwae, fwbe, ref_fwd(rs1e), ref_fwd(rs2e)); end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    resultsrce = 2'b01; rde = 7; rs2d = 7; rs1d = 3; pcsrce = 2'b00;
    @(negedge clk);
    checks++;
    if ({stallf, stalld, flushd, flushe} !== 4'b1101)
      begin errors++; $display("FAIL lduse_ctl: got %b%b%b%b expected 1101", stallf, stalld, flushd, flushe); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL lduse_cnt_before: got %0d expected 0", stall_cnt); end
    advance();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lduse_cnt_after: got %0d expected 1", stall_cnt); end
    idle_inputs();
    advance();
  endtask

  task automatic test_redirect_priority();
    resultsrce = 2'b01; rde = 7; rs2d = 7; pcsrce = 2'b01;
    @(negedge clk);
    checks++;
    if ({stallf, stalld, flushd, flushe} !== 4'b0011)
      begin errors++; $display("FAIL redir_ctl: got %b%b%b%b expected 0011", stallf, stalld, flushd, flushe); end
    advance();
    @(negedge clk);
    checks++;
    if ({stall_cnt, flush_cnt} !== {16'd1, 16'd1})
      begin errors++; $display("FAIL redir_cnt: got stall=%0d flush=%0d expected stall=1 flush=1", stall_cnt, flush_cnt); end
    idle_inputs();
    advance();
  endtask

  task automatic test_saturation();
    pcsrce = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs_cnt !== model_cnt()) begin errors++; $display("FAIL sat_step[%0d]: got %h expected %h", i, obs_cnt, model_cnt()); end
      advance();
    end
    @(negedge clk);
    checks++;
    if (s_flush_cnt !== 2'd3) begin errors++; $display("FAIL sat_flush_w2: got %0d expected 3", s_flush_cnt); end
    checks++;
    if (flush_cnt !== 16'd6) begin errors++; $display("FAIL sat_flush_w16: got %0d expected 6", flush_cnt); end
    idle_inputs();
    advance();
  endtask

  task automatic test_halt_step();
    bit halt_seq [17]   = '{1,1,1,1,1,1,1,1,1,0,0,1,0,0,0,0,0};
    bit step_seq [17]   = '{0,0,0,0,1,0,0,0,0,0,0,0,0,1,0,1,0};
    bit stallf_seq [17] = '{0,1,1,1,1,0,1,1,1,1,0,0,1,1,1,1,0};
    bit ack_seq [17]    = '{0,0,0,0,1,0,0,0,0,1,0,0,0,0,0,1,0};
    for (int i = 0; i < 17; i++) begin
      halt_req = halt_seq[i];
      step     = step_seq[i];
      @(negedge clk);
      checks++;
      if ({stallf, halt_ack} !== {stallf_seq[i], ack_seq[i]})
        begin errors++; $display("FAIL halt_seq[%0d]: got stallf=%b ack=%b expected stallf=%b ack=%b", i, stallf, halt_ack, stallf_seq[i], ack_seq[i]); end
      checks++;
      if (obs_ctl !== model_ctl()) begin errors++; $display("FAIL halt_model[%0d]: got %b expected %b", i, obs_ctl, model_ctl()); end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    halt_req = 1;
    advance();
    @(negedge clk);
    checks++;
    if ({stallf, stalld, flushd, flushe, halt_ack} !== 5'b11010)
      begin errors++; $display("FAIL drain_before_rst: got %b%b%b%b%b expected 11010", stallf, stalld, flushd, flushe, halt_ack); end
    advance();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_ctl !== CTL_INIT) begin errors++; $display("FAIL rst_mid_drain_ctl: got %b expected %b", obs_ctl, CTL_INIT); end
    checks++;
    if (obs_cnt !== '0) begin errors++; $display("FAIL rst_mid_drain_cnt: got %h expected 0", obs_cnt); end
    @(negedge clk);
    rst = 1'b1;
    advance();
    for (int i = 0; i < 20 && m_mode != M_HALTED; i++) advance();
    @(negedge clk);
    checks++;
    if (halt_ack !== 1'b1) begin errors++; $display("FAIL halted_before_rst: got %b expected 1", halt_ack); end
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (halt_ack !== 1'b0) begin errors++; $display("FAIL rst_async_ack: got %b expected 0", halt_ack); end
    advance();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
      rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
      rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3)); rdw = 5'($urandom_range(0, 3));
      regwritem  = 1'($urandom_range(0, 1));
      regwritew  = 1'($urandom_range(0, 1));
      resultsrce = 2'($urandom_range(0, 3));
      pcsrce     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      step = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      checks++;
      if (obs_ctl !== model_ctl()) begin errors++; $display("FAIL rand_ctl[%0d]: got %b expected %b", i, obs_ctl, model_ctl()); end
      checks++;
      if (obs_cnt !== model_cnt()) begin errors++; $display("FAIL rand_cnt[%0d]: got %h expected %h", i, obs_cnt, model_cnt()); end
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 149) == 0) begin
        rst = 1'b0;
        model_reset();
      end
      advance();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect_priority();
    test_saturation();
    test_halt_step();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
